// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM/timer main counter.
package pwm_pkg;

  localparam int CNT_W_DEFAULT = 16;

  // Control-register bit positions feeding this block
  localparam int CTRL_EN   = 2;
  localparam int CTRL_CONT = 3;
  localparam int CTRL_CLR  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_main_counter_if.sv
// Control/status bundle between the control registers and the main counter.
interface pwm_main_counter_if #(
  parameter int CNT_W = pwm_pkg::CNT_W_DEFAULT
);

  logic             counter_en;
  logic             cont_mode;
  logic             counter_clr;
  logic [CNT_W-1:0] divisor_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] counter;
  logic             tick;
  logic             period_end;
  logic             oneshot_done;

  modport master (
    output counter_en, cont_mode, counter_clr, divisor_reg, period_reg,
    input  counter, tick, period_end, oneshot_done
  );

  modport slave (
    input  counter_en, cont_mode, counter_clr, divisor_reg, period_reg,
    output counter, tick, period_end, oneshot_done
  );

endinterface

// File: rtl/pwm_prescaler.sv
// Clock prescaler: divides the selected clock by a programmable divisor.
// tick_evt is the same-cycle terminal strobe used by the counter FSM;
// tick is its registered copy presented to the outside.
module pwm_prescaler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic [CNT_W-1:0] divisor_reg,
  output logic             tick_evt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] divisor_sync;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_eff;
  logic             terminal;

  // Effective divisor (0 behaves as 1); >= keeps a lowered divisor from running away
  always_comb begin
    div_eff  = (divisor_sync == {CNT_W{1'b0}}) ? ONE : divisor_sync;
    terminal = (div_cnt >= (div_eff - ONE));
    tick_evt = run & terminal;
  end

  // Divisor sync register, divide counter and registered tick
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor_sync <= {CNT_W{1'b0}};
      div_cnt      <= {CNT_W{1'b0}};
      tick         <= 1'b0;
    end else begin
      divisor_sync <= divisor_reg;
      if (clr) begin
        div_cnt <= {CNT_W{1'b0}};
        tick    <= 1'b0;
      end else if (run) begin
        div_cnt <= terminal ? {CNT_W{1'b0}} : (div_cnt + ONE);
        tick    <= terminal;
      end else begin
        tick    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_main_counter.sv
// Main up-counter of the PWM/timer core: counts prescaled ticks up to the
// period register, wrapping (continuous) or freezing (one-shot).
module pwm_main_counter
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic              chosen_clk,
  input  logic              rst,
  pwm_main_counter_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] period_sync;
  logic             period_end;
  logic             period_end_next;
  logic             done;
  logic             done_next;
  logic             run;
  logic             tick_evt;
  logic             tick;
  logic             at_period;

  assign run       = (state == RUN) & bus.counter_en & ~bus.counter_clr;
  assign at_period = (cnt >= period_sync);

  pwm_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk         (chosen_clk),
    .rst         (rst),
    .run         (run),
    .clr         (bus.counter_clr),
    .divisor_reg (bus.divisor_reg),
    .tick_evt    (tick_evt),
    .tick        (tick)
  );

  // FSM state register
  always_ff @(posedge chosen_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; clear overrides the normal transitions
  always_comb begin
    state_next = state;
    if (bus.counter_clr) begin
      state_next = bus.counter_en ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next = bus.counter_en ? RUN : IDLE;
        end
        RUN: begin
          if (!bus.counter_en) begin
            state_next = IDLE;
          end else if (tick_evt && at_period && !bus.cont_mode) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (!bus.counter_en) begin
            state_next = IDLE;
          end else if (bus.cont_mode) begin
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Next counter, period pulse and one-shot flag
  always_comb begin
    cnt_next        = cnt;
    period_end_next = 1'b0;
    done_next       = done;
    if (bus.counter_clr) begin
      cnt_next  = {CNT_W{1'b0}};
      done_next = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.counter_en && tick_evt) begin
            if (at_period) begin
              period_end_next = 1'b1;
              if (bus.cont_mode) begin
                cnt_next = {CNT_W{1'b0}};
              end else begin
                done_next = 1'b1;
              end
            end else begin
              cnt_next = cnt + ONE;
            end
          end else begin
            cnt_next = cnt;
          end
        end
        DONE: begin
          if (bus.counter_en && bus.cont_mode) begin
            cnt_next  = {CNT_W{1'b0}};
            done_next = 1'b0;
          end else begin
            cnt_next = cnt;
          end
        end
        default: begin
          cnt_next = cnt;
        end
      endcase
    end
  end

  // Registered outputs and period synchronisation
  always_ff @(posedge chosen_clk) begin
    if (rst) begin
      cnt         <= {CNT_W{1'b0}};
      period_end  <= 1'b0;
      done        <= 1'b0;
      period_sync <= {CNT_W{1'b0}};
    end else begin
      cnt         <= cnt_next;
      period_end  <= period_end_next;
      done        <= done_next;
      period_sync <= bus.period_reg;
    end
  end

  assign bus.counter      = cnt;
  assign bus.tick         = tick;
  assign bus.period_end   = period_end;
  assign bus.oneshot_done = done;

endmodule

// File: tb/tb_pwm_main_counter.sv
// Scoreboard bench for pwm_main_counter: a behavioural model predicts the
// outputs after each clock edge; a monitor compares on the falling edge.
module tb_pwm_main_counter;

  logic clk;
  logic rst;

  pwm_main_counter_if #(.CNT_W(16)) bus ();

  pwm_main_counter #(.CNT_W(16)) dut (
    .chosen_clk (clk),
    .rst        (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] counter;
    logic        tick;
    logic        period_end;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  // Behavioural model: "running" means ticks are counted, "finished" means a
  // one-shot run has ended, otherwise the counter is paused.
  bit running  = 0;
  bit finished = 0;
  int pres     = 0;
  int count    = 0;
  int div_seen = 0;
  int per_seen = 0;
  bit done_f   = 0;

  task automatic model_step(input bit r, input bit en, input bit cont, input bit clr,
                            input int div, input int per);
    exp_t e;
    int   eff;
    bit   t, pe;
    t  = 0;
    pe = 0;
    eff = (div_seen == 0) ? 1 : div_seen;
    if (r) begin
      running = 0; finished = 0; pres = 0; count = 0; done_f = 0;
      div_seen = 0; per_seen = 0;
    end else begin
      if (clr) begin
        count = 0; pres = 0; done_f = 0;
        running = en; finished = 0;
      end else if (running) begin
        if (!en) begin
          running = 0;
        end else begin
          if (pres + 1 >= eff) begin
            pres = 0;
            t = 1;
            if (count >= per_seen) begin
              pe = 1;
              if (cont) count = 0;
              else begin
                running = 0; finished = 1; done_f = 1;
              end
            end else begin
              count = (count + 1) % 65536;
            end
          end else begin
            pres = pres + 1;
          end
        end
      end else if (finished) begin
        if (!en) finished = 0;
        else if (cont) begin
          finished = 0; running = 1; count = 0; done_f = 0;
        end
      end else begin
        if (en) running = 1;
      end
      div_seen = div;
      per_seen = per;
    end
    e.counter    = count[15:0];
    e.tick       = t;
    e.period_end = pe;
    e.done       = done_f;
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit en, input bit cont, input bit clr,
                       input int div, input int per);
    rst             = r;
    bus.counter_en  = en;
    bus.cont_mode   = cont;
    bus.counter_clr = clr;
    bus.divisor_reg = div[15:0];
    bus.period_reg  = per[15:0];
    model_step(r, en, cont, clr, div, per);
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input int n, input bit en, input bit cont, input int div, input int per);
    for (int i = 0; i < n; i++) drive(1'b0, en, cont, 1'b0, div, per);
  endtask

  task automatic run_until(input int target, input int limit, input bit cont,
                           input int div, input int per, input string name);
    int k;
    k = 0;
    while (count != target && k < limit) begin
      drive(1'b0, 1'b1, cont, 1'b0, div, per);
      k++;
    end
    tests++;
    if (count != target) begin
      fails++;
      $display("FAIL %s: model counter %0d, required %0d within %0d cycles", name, count, target, limit);
    end
  endtask

  // Monitor: one expected entry per clock edge, checked on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (bus.counter !== e.counter) begin
          fails++;
          $display("FAIL counter @%0d: got %0h required %0h", cycle, bus.counter, e.counter);
        end
        tests++;
        if (bus.tick !== e.tick) begin
          fails++;
          $display("FAIL tick @%0d: got %b required %b", cycle, bus.tick, e.tick);
        end
        tests++;
        if (bus.period_end !== e.period_end) begin
          fails++;
          $display("FAIL period_end @%0d: got %b required %b", cycle, bus.period_end, e.period_end);
        end
        tests++;
        if (bus.oneshot_done !== e.done) begin
          fails++;
          $display("FAIL oneshot_done @%0d: got %b required %b", cycle, bus.oneshot_done, e.done);
        end
      end
    end
  end

  // Global time limit
  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    // Divisor 0, period 3, continuous
    phase(20, 1'b1, 1'b1, 0, 3);
    // Divisor 4, period 2
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4, 2);
    phase(40, 1'b1, 1'b1, 4, 2);
    // One-shot, divisor 1, period 5, then restart in continuous mode
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1, 5);
    phase(20, 1'b1, 1'b0, 1, 5);
    phase(10, 1'b1, 1'b1, 1, 5);
    // Clear at counter 7 with period 10, then reset mid-run
    run_until(7, 40, 1'b1, 0, 10, "reach_7");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 0, 10);
    phase(5, 1'b1, 1'b1, 0, 10);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 10);
    // Pause at counter 4 for five cycles
    run_until(4, 40, 1'b1, 0, 10, "reach_4");
    phase(5, 1'b0, 1'b1, 0, 10);
    phase(3, 1'b1, 1'b1, 0, 10);
    // Period lowered from 20 to 3 while counter is 10
    drive(1'b0, 1'b1, 1'b1, 1'b1, 0, 20);
    run_until(10, 60, 1'b1, 0, 20, "reach_10");
    phase(6, 1'b1, 1'b1, 0, 3);
    // Period 0
    phase(12, 1'b1, 1'b1, 2, 0);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
            $urandom_range(0, 5), $urandom_range(0, 15));
    end
    // Period 0xFFFF wraps to 0 after 0xFFFF
    drive(1'b0, 1'b1, 1'b1, 1'b1, 0, 65535);
    run_until(65535, 66000, 1'b1, 0, 65535, "reach_ffff");
    phase(3, 1'b1, 1'b1, 0, 65535);
    // Drain the scoreboard
    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #6;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
